// File: rtl/decoder_nx2n_scan_if.sv
// Control and decoded-output bundle for decoder_nx2n_scan.
// The master side drives the select and scan controls; the slave side returns the registered outputs.
interface decoder_nx2n_scan_if #(
   parameter int N       = 3,
   parameter int DWELL_W = 8
);
   logic               en;
   logic               mode;
   logic [N-1:0]       sel_in;
   logic               sel_valid;
   logic [DWELL_W-1:0] dwell;
   logic [2**N-1:0]    dout;
   logic [N-1:0]       cur_sel;
   logic               wrap;

   modport master (
      output en, mode, sel_in, sel_valid, dwell,
      input  dout, cur_sel, wrap
   );

   modport slave (
      input  en, mode, sel_in, sel_valid, dwell,
      output dout, cur_sel, wrap
   );
endinterface

// File: rtl/decoder_nx2n_scan.sv
// Registered N-to-2^N one-hot decoder with direct-load and auto-scan modes; 1-cycle latency.
// No backpressure: sel_valid is a one-cycle qualifier that is always accepted.
module decoder_nx2n_scan #(
   parameter int N          = 3,
   parameter int DWELL_W    = 8,
   parameter int ACTIVE_LOW = 0
) (
   input logic                 clk,
   input logic                 rst,
   decoder_nx2n_scan_if.slave  bus
);
   localparam int W = 2**N;
   localparam logic [W-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

   typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

   state_t             state_q, state_d;
   logic [N-1:0]       sel_q, sel_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]       dout_q, dout_d;
   logic               wrap_q, wrap_d;
   logic [W-1:0]       one_hot;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         cnt_q   <= '0;
         dout_q  <= INACTIVE;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         wrap_q  <= wrap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      wrap_d  = 1'b0;
      one_hot = '0;
      dout_d  = INACTIVE;

      if (!bus.en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = bus.mode ? SCAN : DIRECT;
               cnt_d   = '0;
               if (bus.sel_valid) sel_d = bus.sel_in;
            end
            DIRECT: begin
               if (bus.mode) begin
                  state_d = SCAN;
                  cnt_d   = '0;
               end
               if (bus.sel_valid) sel_d = bus.sel_in;
            end
            SCAN: begin
               if (!bus.mode) begin
                  state_d = DIRECT;
                  cnt_d   = '0;
                  if (bus.sel_valid) sel_d = bus.sel_in;
               end else if (bus.sel_valid) begin
                  // A load always beats the dwell advance and suppresses wrap.
                  sel_d = bus.sel_in;
                  cnt_d = '0;
               end else if (cnt_q == bus.dwell) begin
                  cnt_d  = '0;
                  sel_d  = sel_q + N'(1);
                  wrap_d = (sel_q == {N{1'b1}});
               end else begin
                  cnt_d = cnt_q + DWELL_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Decode from next-state sel so dout and cur_sel move on the same edge.
      one_hot = {{(W-1){1'b0}}, 1'b1} << sel_d;
      if (state_d != IDLE) dout_d = one_hot ^ INACTIVE;
   end

   assign bus.dout    = dout_q;
   assign bus.cur_sel = sel_q;
   assign bus.wrap    = wrap_q;
endmodule

// File: doc/decoder_nx2n_scan.md
Name: decoder_nx2n_scan

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with enable, in the combinational decoder family.
- Two modes. Direct mode latches a select on a valid strobe. Scan mode auto-cycles through all outputs with a programmable dwell time.
- Typical use: display digit/row strobing and channel-select fan-out, where a glitch-free registered one-hot bus is required.

Parameters:
- N, 3, select width; output width is 2^N.
- DWELL_W, 8, width of the dwell-count input and the internal dwell counter.
- ACTIVE_LOW, 0, 1 inverts every dout bit (inactive = 1, selected = 0).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable; 0 forces dout inactive and the FSM to IDLE.
- mode  input  1  0 = DIRECT, 1 = SCAN; sampled every cycle.
- sel_in  input  N  select value to load.
- sel_valid  input  1  load strobe for sel_in; one-cycle qualifier, no backpressure.
- dwell  input  DWELL_W  scan dwell; each output stays selected for dwell+1 cycles.
- dout  output  2^N  registered one-hot (or one-cold) decoded output.
- cur_sel  output  N  registered current select value.
- wrap  output  1  one-cycle pulse when scan advances from 2^N-1 to 0.

Behaviour:
- Reset (rst=1 at an edge; overrides everything, including mid-scan):
  - state = IDLE, sel = 0, dwell counter cnt = 0, cur_sel = 0, wrap = 0.
  - dout = all inactive: all 0, or all 1 if ACTIVE_LOW.
- Registered outputs:
  - dout and cur_sel are both registers, computed from next-state sel, so they always change on the same edge.
  - dout is never combinationally driven from inputs.
- Decode rule:
  - In DIRECT/SCAN, dout bit k is active iff k == sel; exactly one bit is active.
  - In IDLE, no bit is active.
- FSM states: IDLE, DIRECT, SCAN.
  - Any state, en=0: go to IDLE next edge; sel and cnt hold; dout inactive from that edge; wrap = 0.
  - IDLE, en=1: go to DIRECT if mode=0, else SCAN. cnt is cleared. dout shows decode(sel) on the same edge, i.e. 1 cycle after en rises. A sel_valid in that cycle is honoured.
  - DIRECT, en=1, mode=1: go to SCAN; cnt = 0; sel kept, so scan resumes from the current output.
  - SCAN, en=1, mode=0: go to DIRECT; sel frozen at its current value; cnt = 0.
- DIRECT mode:
  - sel_valid=1 loads sel = sel_in; dout/cur_sel update on that edge (latency 1 cycle).
  - sel_valid=0: hold.
- SCAN mode:
  - cnt increments each cycle.
  - When cnt == dwell: cnt becomes 0 and sel becomes sel+1, modulo 2^N.
  - On the 2^N-1 -> 0 step, wrap = 1 for exactly that cycle.
  - dwell=0: advance every cycle.
  - dwell may change mid-scan. The compare uses the live value; if cnt already exceeds the new dwell, cnt continues up and wraps at 2^DWELL_W to 0 (no special handling).
- Simultaneous events in SCAN:
  - sel_valid has priority over the dwell advance: sel = sel_in, cnt = 0, wrap = 0, even if cnt == dwell in that cycle.
- Priority order: rst > en=0 > sel_valid > dwell advance.
- Width rules:
  - sel and cur_sel are N bits; cnt is DWELL_W bits.
  - The increment wraps naturally; no saturation.

Test Plan:
- Reset/idle: assert rst 2 cycles, en=0 -> dout=8'h00, cur_sel=0, wrap=0. With ACTIVE_LOW=1 -> dout=8'hFF.
- Direct load, N=3: en=1, mode=0; sel_valid pulse with sel_in=5 -> one cycle later dout=8'h20, cur_sel=5; holds while sel_valid=0.
- Scan with dwell=2: en=1, mode=1, from sel=0 -> dout steps 8'h01, 8'h02, 8'h04 ... 8'h80, each held 3 cycles; wrap=1 for exactly the single cycle dout returns to 8'h01.
- Scan with dwell=0 -> output advances every cycle; wrap pulses every 8 cycles.
- Priority collision in SCAN, dwell=0: sel_valid=1 with sel_in=2 -> dout=8'h04 next cycle (not sel+1), wrap=0. Next edge -> 8'h08.
- Disable/reset mid-scan:
  - en=0 at sel=6 -> dout=0 next edge.
  - en=1 again -> dout=8'h40 one cycle later; scan resumes with a full dwell.
  - rst asserted mid-scan -> all outputs return to reset values on that edge.
